// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/compare ops plus
// iterative unsigned multiply and restoring divide, with valid/ready on both sides.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alucont,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             dz,
  output logic             busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNTW-1:0]  r_cnt;
  logic             r_vld, r_zero, r_ovf, r_dz;
  logic [WIDTH-1:0] r_result, r_hi;
  logic [WIDTH-1:0] r_acc, r_lo, r_mcd;

  logic             w_acc, w_multi, w_last;
  logic [WIDTH-1:0] w_bb;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf_raw;
  logic [WIDTH-1:0] w_sc_res, w_sc_hi;
  logic             w_sc_ovf, w_sc_dz;
  logic [WIDTH:0]   w_mul_sum, w_div_sh;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_df;
  logic [WIDTH-1:0] w_step_acc, w_step_lo;

  assign in_ready  = (r_state == S_IDLE) && (!r_vld || out_ready);
  assign w_acc     = in_valid && in_ready;
  assign w_multi   = (alucont == OP_MULU) || ((alucont == OP_DIVU) && (b != '0));
  assign w_last    = (r_cnt == CNTW'(1));

  assign out_valid = r_vld;
  assign result    = r_result;
  assign hi        = r_hi;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign dz        = r_dz;
  assign busy      = (r_state != S_IDLE);

  // alucont[2] selects subtract: invert B and carry in 1
  assign w_bb      = alucont[2] ? ~b : b;
  assign w_sum     = {1'b0, a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, alucont[2]};
  assign w_ovf_raw = (a[WIDTH-1] == w_bb[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    w_sc_res = '0;
    w_sc_hi  = '0;
    w_sc_ovf = 1'b0;
    w_sc_dz  = 1'b0;
    case (alucont)
      OP_AND:  w_sc_res = a & b;
      OP_OR:   w_sc_res = a | b;
      OP_XOR:  w_sc_res = a ^ b;
      OP_NOR:  w_sc_res = ~(a | b);
      OP_ADD, OP_SUB: begin
        w_sc_res = w_sum[WIDTH-1:0];
        w_sc_ovf = w_ovf_raw;
      end
      OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf_raw};
      OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, ~w_sum[WIDTH]};
      OP_DIVU: begin
        w_sc_res = '1;
        w_sc_hi  = a;
        w_sc_dz  = 1'b1;
      end
      default: ;
    endcase
  end

  // Multiply: add multiplicand into the high half when LSB of LO is set, shift right.
  assign w_mul_sum = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_mcd} : '0);
  // Divide: shift next dividend bit into remainder, subtract divisor when it fits.
  assign w_div_sh  = {r_acc, r_lo[WIDTH-1]};
  assign w_div_ge  = (w_div_sh >= {1'b0, r_mcd});
  assign w_div_df  = w_div_sh[WIDTH-1:0] - r_mcd;

  always_comb begin
    w_step_acc = r_acc;
    w_step_lo  = r_lo;
    if (r_state == S_MUL) begin
      w_step_acc = w_mul_sum[WIDTH:1];
      w_step_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end else if (r_state == S_DIV) begin
      w_step_acc = w_div_ge ? w_div_df : w_div_sh[WIDTH-1:0];
      w_step_lo  = {r_lo[WIDTH-2:0], w_div_ge};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc && (alucont == OP_MULU))
          w_state_nxt = S_MUL;
        else if (w_acc && (alucont == OP_DIVU) && (b != '0))
          w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_vld    <= 1'b0;
      r_result <= '0;
      r_hi     <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc && w_multi)
        r_cnt <= CNT_INIT;
      else if (r_state != S_IDLE)
        r_cnt <= r_cnt - 1'b1;

      if (w_acc && !w_multi) begin
        r_result <= w_sc_res;
        r_hi     <= w_sc_hi;
        r_zero   <= (w_sc_res == '0);
        r_ovf    <= w_sc_ovf;
        r_dz     <= w_sc_dz;
        r_vld    <= 1'b1;
      end else if ((r_state != S_IDLE) && w_last) begin
        r_result <= w_step_lo;
        r_hi     <= w_step_acc;
        r_zero   <= (w_step_lo == '0);
        r_ovf    <= 1'b0;
        r_dz     <= 1'b0;
        r_vld    <= 1'b1;
      end else if (out_ready) begin
        r_vld <= 1'b0;
      end
    end
  end

  // Iteration working registers; only meaningful while busy, so no reset.
  always_ff @(posedge clk) begin
    if (w_acc && w_multi) begin
      r_acc <= '0;
      r_lo  <= (alucont == OP_MULU) ? b : a;
      r_mcd <= (alucont == OP_MULU) ? a : b;
    end else if (r_state != S_IDLE) begin
      r_acc <= w_step_acc;
      r_lo  <= w_step_lo;
    end
  end

endmodule
